// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared channel state encoding, default sizes and round-robin helper.
package tick_sched_pkg;
  typedef enum logic [1:0] {CH_IDLE = 2'd0, CH_RUN = 2'd1, CH_PEND = 2'd2} ch_state_t;
  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 16;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/tick_sched_channel.sv
// tick_sched_channel: one countdown timer channel (IDLE -> RUN -> PEND -> IDLE) with sticky overrun.
module tick_sched_channel
  import tick_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] load_i,
  input  logic             pop_i,
  input  logic             hold_i,
  output ch_state_t        state_o,
  output logic             busy_o,
  output logic             overrun_o
);
  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // A start on a pending channel is refused so the expiry is never lost.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q | (start_i && state_q == CH_PEND);
    if (pop_i) begin
      state_d = CH_IDLE;
    end else if (start_i) begin
      if (state_q != CH_PEND) begin
        cnt_d   = load_i;
        state_d = (load_i == '0) ? CH_PEND : CH_RUN;
      end
    end else if (stop_i && !hold_i) begin
      state_d = CH_IDLE;
    end else if (tick_i && state_q == CH_RUN && cnt_q != '0) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == CNT_W'(1)) ? CH_PEND : CH_RUN;
    end
  end

  always_comb begin
    state_o   = state_q;
    busy_o    = state_q != CH_IDLE;
    overrun_o = ovr_q;
  end
endmodule

// File: rtl/tick_timer_scheduler.sv
// tick_timer_scheduler: NUM_CH tick-driven countdown timers sharing one round-robin expiry port.
module tick_timer_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      tick_in,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH*CNT_W-1:0]   load_val,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         overrun,
  output logic                      exp_valid,
  output logic [$clog2(NUM_CH)-1:0] exp_ch,
  input  logic                      exp_ready
);
  localparam int CH_W = $clog2(NUM_CH);

  logic            exp_valid_q, exp_valid_d;
  logic [CH_W-1:0] exp_ch_q, exp_ch_d, rr_ptr_q, rr_ptr_d, idx;
  logic            hs, found;
  logic [NUM_CH-1:0] pend, pop, hold, cand;

  assign hs = exp_valid_q && exp_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t st;
    tick_sched_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .start_i  (start[i]),
      .stop_i   (stop[i]),
      .tick_i   (tick_in),
      .load_i   (load_val[i*CNT_W +: CNT_W]),
      .pop_i    (pop[i]),
      .hold_i   (hold[i]),
      .state_o  (st),
      .busy_o   (busy[i]),
      .overrun_o(overrun[i])
    );
    assign pend[i] = st == CH_PEND;
    assign hold[i] = exp_valid_q && exp_ch_q == CH_W'(i);
    assign pop[i]  = hold[i] && exp_ready;
  end

  // Channels leaving PEND this cycle (popped or cancelled) must not be picked.
  assign cand = pend & ~pop & ~(stop & ~start);

  always_comb begin
    rr_ptr_d    = hs ? CH_W'(rr_next(int'(exp_ch_q), NUM_CH)) : rr_ptr_q;
    exp_valid_d = exp_valid_q;
    exp_ch_d    = exp_ch_q;
    found       = 1'b0;
    idx         = '0;
    if (!exp_valid_q || hs) begin
      exp_valid_d = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        idx = CH_W'((int'(rr_ptr_d) + k) % NUM_CH);
        if (!found && cand[idx]) begin
          found       = 1'b1;
          exp_valid_d = 1'b1;
          exp_ch_d    = idx;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      exp_valid_q <= 1'b0;
      exp_ch_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      exp_valid_q <= exp_valid_d;
      exp_ch_q    <= exp_ch_d;
    end
  end

  assign exp_valid = exp_valid_q;
  assign exp_ch    = exp_ch_q;
endmodule
